// File: rtl/pwr_domain_chain.sv
// pwr_domain_chain
// Chain of NUM_DOMAINS power-gated pipeline stages on one clock. Each stage has
// its own power FSM (OFF -> PWR_UP -> ON -> ISO -> OFF), a settle counter and an
// output isolation clamp. Data advances one stage per cycle through ON domains;
// a domain that is not ON drives ISO_VALUE with valid low downstream.
//
// Optional feature: define PWR_DOMAIN_RETENTION_EN to keep stage data/valid
// across ISO/OFF/PWR_UP. Without it, stage contents are cleared on entry to OFF.
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst         synchronous active-high reset
//   pwr_req     [NUM_DOMAINS] per-domain power request (1 = on)
//   data_in     [WIDTH] stage-0 data
//   in_valid    data_in qualifier
//   pwr_ack     [NUM_DOMAINS] 1 while domain is ON
//   iso_active  [NUM_DOMAINS] 1 while domain is not ON
//   data_out    [WIDTH] clamped last-stage data
//   out_valid   clamped last-stage valid

// One power domain: FSM, settle counter, stage register and clamp.
module pwr_domain_stage #(
    parameter int               WIDTH         = 32,
    parameter int               SETTLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] ISO_VALUE     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr_req,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    output logic             pwr_ack,
    output logic             iso_active,
    output logic [WIDTH-1:0] cl_data,
    output logic             cl_valid
);
    typedef enum logic [1:0] {OFF, PWR_UP, ON, ISO} state_t;

    localparam int            CW   = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] LOAD = CW'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            OFF: begin
                if (pwr_req) begin
                    state_d = PWR_UP;
                    cnt_d   = LOAD;
                end
            end
            PWR_UP: begin
                if (!pwr_req)         state_d = OFF;
                else if (cnt_q == '0) state_d = ON;
                else                  cnt_d   = cnt_q - 1'b1;
            end
            ON: begin
                // Capture every cycle while ON, including the cycle we leave.
                data_d  = up_data;
                valid_d = up_valid;
                if (!pwr_req) state_d = ISO;
            end
            ISO:     state_d = OFF;
            default: state_d = OFF;
        endcase
`ifndef PWR_DOMAIN_RETENTION_EN
        // Contents are lost when the domain actually powers off.
        if (state_q != OFF && state_d == OFF) begin
            data_d  = '0;
            valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign pwr_ack    = (state_q == ON);
    assign iso_active = ~pwr_ack;
    assign cl_data    = iso_active ? ISO_VALUE : data_q;
    assign cl_valid   = iso_active ? 1'b0 : valid_q;
endmodule

module pwr_domain_chain #(
    parameter int               WIDTH         = 32,
    parameter int               NUM_DOMAINS   = 3,
    parameter int               SETTLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] ISO_VALUE     = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_DOMAINS-1:0] pwr_req,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   in_valid,
    output logic [NUM_DOMAINS-1:0] pwr_ack,
    output logic [NUM_DOMAINS-1:0] iso_active,
    output logic [WIDTH-1:0]       data_out,
    output logic                   out_valid
);
    // Link i feeds stage i; link NUM_DOMAINS is the chain output.
    logic [NUM_DOMAINS:0][WIDTH-1:0] ch_data;
    logic [NUM_DOMAINS:0]            ch_valid;

    assign ch_data[0]  = data_in;
    assign ch_valid[0] = in_valid;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        pwr_domain_stage #(
            .WIDTH         (WIDTH),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .ISO_VALUE     (ISO_VALUE)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .pwr_req    (pwr_req[i]),
            .up_data    (ch_data[i]),
            .up_valid   (ch_valid[i]),
            .pwr_ack    (pwr_ack[i]),
            .iso_active (iso_active[i]),
            .cl_data    (ch_data[i+1]),
            .cl_valid   (ch_valid[i+1])
        );
    end

    assign data_out  = ch_data[NUM_DOMAINS];
    assign out_valid = ch_valid[NUM_DOMAINS];
endmodule
